// File: rtl/apb_bridge_pkg.sv
// Shared types, default address window and helpers for the core-to-APB request bridge.
package apb_bridge_pkg;

    localparam int unsigned CORE_ADDR_W = 32;
    localparam int unsigned CORE_DATA_W = 32;
    localparam int unsigned CORE_BE_W   = 4;

    // Peripheral window on the SoC address map (inclusive bounds).
    localparam logic [CORE_ADDR_W-1:0] APB_ADDR_LO = 32'h1A10_0000;
    localparam logic [CORE_ADDR_W-1:0] APB_ADDR_HI = 32'h1B00_5FFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_br_state_e;

    // Response payload returned to the core with rvalid.
    typedef struct packed {
        logic                   err;
        logic [CORE_DATA_W-1:0] rdata;
    } apb_rsp_t;

    // True when addr lies inside [lo, hi].
    function automatic logic in_range(
        input logic [CORE_ADDR_W-1:0] addr,
        input logic [CORE_ADDR_W-1:0] lo,
        input logic [CORE_ADDR_W-1:0] hi
    );
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/apb_bus.sv
// APB3 bus bundle shared by the bridge and the peripheral interconnect.
interface APB_BUS #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS wait cycles and flags when the programmed limit is reached.
module apb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    generate
        if (LIMIT == 0) begin : g_off
            // Timeout disabled: never expires.
            logic w_unused;
            assign w_unused    = ^{clk, rst_n, i_clear, i_enable};
            assign o_expired_c = 1'b0;
        end else begin : g_cnt
            localparam int unsigned CNT_W = $clog2(LIMIT + 1);

            logic [CNT_W-1:0] r_cnt;

            // Wait-cycle counter; saturates at LIMIT, cleared before each ACCESS.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (i_clear) begin
                    r_cnt <= '0;
                end else if (i_enable && (r_cnt != CNT_W'(LIMIT))) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign o_expired_c = (r_cnt == CNT_W'(LIMIT));
        end
    endgenerate

endmodule

// File: rtl/apb_req_bridge.sv
// Converts core req/gnt/rvalid accesses into single APB3 transfers with
// window check, partial-write rejection and hung-slave timeout.
module apb_req_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned              APB_ADDR_WIDTH = 32,
    parameter int unsigned              APB_DATA_WIDTH = 32,
    parameter logic [CORE_ADDR_W-1:0]   ADDR_LO        = APB_ADDR_LO,
    parameter logic [CORE_ADDR_W-1:0]   ADDR_HI        = APB_ADDR_HI,
    parameter int unsigned              TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_i,
    input  logic [CORE_ADDR_W-1:0] addr_i,
    input  logic                   we_i,
    input  logic [CORE_BE_W-1:0]   be_i,
    input  logic [CORE_DATA_W-1:0] wdata_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [CORE_DATA_W-1:0] rdata_o,
    output logic                   err_o,
    APB_BUS.Master                 apb_master
);

    apb_br_state_e             r_state;
    apb_br_state_e             w_state_nxt;

    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_rvalid;
    apb_rsp_t                  r_rsp;

    logic                      w_psel_nxt;
    logic                      w_penable_nxt;
    logic                      w_rvalid_nxt;
    apb_rsp_t                  w_rsp_nxt;
    logic                      w_load;
    logic                      w_legal;
    logic                      w_cnt_clear;
    logic                      w_cnt_en;
    logic                      w_expired;

    // A request is forwarded only when inside the window and not a partial write.
    assign w_legal = in_range(addr_i, ADDR_LO, ADDR_HI) && !(we_i && (be_i != 4'hF));

    // Counter restarts while in SETUP so every ACCESS phase begins at zero.
    assign w_cnt_clear = (r_state == ST_SETUP);
    assign w_cnt_en    = (r_state == ST_ACCESS) && !apb_master.pready;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_cnt_clear),
        .i_enable    (w_cnt_en),
        .o_expired_c (w_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; pready beats the timeout in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_rvalid_nxt  = 1'b0;
        w_rsp_nxt     = r_rsp;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    if (w_legal) begin
                        w_state_nxt = ST_SETUP;
                        w_psel_nxt  = 1'b1;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt  = ST_RESP;
                        w_rvalid_nxt = 1'b1;
                        w_rsp_nxt    = '{err: 1'b1, rdata: '0};
                    end
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (apb_master.pready) begin
                    w_state_nxt     = ST_RESP;
                    w_rvalid_nxt    = 1'b1;
                    w_rsp_nxt.err   = apb_master.pslverr;
                    w_rsp_nxt.rdata = r_pwrite ? '0 : CORE_DATA_W'(apb_master.prdata);
                end else if (w_expired) begin
                    w_state_nxt  = ST_RESP;
                    w_rvalid_nxt = 1'b1;
                    w_rsp_nxt    = '{err: 1'b1, rdata: '0};
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered APB strobes, held request payload and core response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rvalid  <= 1'b0;
            r_rsp     <= '0;
        end else begin
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rsp     <= w_rsp_nxt;
            if (w_load) begin
                r_paddr  <= APB_ADDR_WIDTH'(addr_i);
                r_pwdata <= APB_DATA_WIDTH'(wdata_i);
                r_pwrite <= we_i;
            end
        end
    end

    assign gnt_o    = (r_state == ST_IDLE) && req_i;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rsp.rdata;
    assign err_o    = r_rsp.err;

    assign apb_master.psel    = r_psel;
    assign apb_master.penable = r_penable;
    assign apb_master.pwrite  = r_pwrite;
    assign apb_master.paddr   = r_paddr;
    assign apb_master.pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Scoreboard bench for apb_req_bridge: random core requests against a random-latency APB slave.
module tb_apb_req_bridge;

    localparam logic [31:0] LO  = 32'h1A10_0000;
    localparam logic [31:0] HI  = 32'h1B00_5FFF;
    localparam int          TMO = 8;
    localparam int          NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    APB_BUS #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb ();

    apb_req_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .ADDR_LO        (LO),
        .ADDR_HI        (HI),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .apb_master (apb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Current transaction as seen by the slave and the bus checker.
    int          cfg_wait   = 0;
    logic        cfg_slverr = 1'b0;
    logic [31:0] cfg_rdata  = '0;
    logic        cur_legal  = 1'b0;
    logic [31:0] cur_addr   = '0;
    logic [31:0] cur_wdata  = '0;
    logic        cur_we     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: response content and the cycle rvalid must appear in.
    function automatic exp_t model(input logic [31:0] a, input logic w, input logic [3:0] b,
                                   input int wt, input logic se, input logic [31:0] rd,
                                   input int issue);
        exp_t e;
        logic legal;
        legal = (a >= LO) && (a <= HI) && (!w || (b == 4'hF));
        if (!legal) begin
            e.err = 1'b1; e.rdata = '0; e.cyc = issue + 1;
        end else if (wt <= TMO) begin
            e.err = se; e.rdata = w ? 32'h0 : rd; e.cyc = issue + 3 + wt;
        end else begin
            e.err = 1'b1; e.rdata = '0; e.cyc = issue + 3 + TMO;
        end
        return e;
    endfunction

    // APB slave: pready after cfg_wait ACCESS cycles, junk on pready/pslverr/prdata otherwise.
    initial begin
        int acc_k;
        acc_k       = 0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        forever begin
            @(negedge clk);
            if (apb.psel && apb.penable) begin
                if (acc_k == cfg_wait) begin
                    apb.pready  = 1'b1;
                    apb.pslverr = cfg_slverr;
                    apb.prdata  = cfg_rdata;
                end else begin
                    apb.pready  = 1'b0;
                    apb.pslverr = 1'($urandom);
                    apb.prdata  = $urandom;
                end
                acc_k++;
            end else begin
                acc_k       = 0;
                apb.pready  = 1'($urandom);
                apb.pslverr = 1'($urandom);
                apb.prdata  = $urandom;
            end
        end
    end

    // Monitor: bus-payload checks while selected, scoreboard pop on every rvalid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (apb.penable) chk("penable_without_psel", 32'(apb.psel), 32'd1);
            if (apb.psel) begin
                chk("psel_on_rejected", 32'(cur_legal), 32'd1);
                chk("paddr", apb.paddr, cur_addr);
                chk("pwrite", 32'(apb.pwrite), 32'(cur_we));
                if (cur_we) chk("pwdata", apb.pwdata, cur_wdata);
            end
            if (rvalid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got 1 want 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rdata", rdata_o, mon_e.rdata);
                    chk("err", 32'(err_o), 32'(mon_e.err));
                    chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("sel_low_in_resp", 32'({apb.psel, apb.penable}), 32'd0);
                    if (cur_legal) chk("paddr_hold", apb.paddr, cur_addr);
                end
            end
        end
    end

    // One core transaction; returns at a negedge with the bridge idle.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] wd, input int wt, input logic se,
                          input logic [31:0] rd);
        int n;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        cfg_wait   = wt;
        cfg_slverr = se;
        cfg_rdata  = rd;
        cur_legal  = (a >= LO) && (a <= HI) && (!w || (b == 4'hF));
        cur_addr   = a;
        cur_we     = w;
        cur_wdata  = wd;
        addr_i  = a;
        we_i    = w;
        be_i    = b;
        wdata_i = wd;
        req_i   = 1'b1;
        exp_q.push_back(model(a, w, b, wt, se, rd, cyc));
        #1 chk("gnt_in_idle", 32'(gnt_o), 32'd1);
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
            #1 chk("gnt_when_busy", 32'(gnt_o), 32'd0);
            @(negedge clk);
        end
        req_i   = 1'b0;
        addr_i  = $urandom;
        wdata_i = $urandom;
        we_i    = 1'($urandom);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL response_timeout: got no rvalid want rvalid (cycle %0d)", cyc);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Reset in the middle of a hung ACCESS phase.
    task automatic reset_mid();
        int n;
        int rv;
        cfg_wait  = NEVER;
        cur_legal = 1'b1;
        cur_addr  = LO + 32'h100;
        cur_we    = 1'b0;
        addr_i    = cur_addr;
        we_i      = 1'b0;
        be_i      = 4'hF;
        req_i     = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        n = 0;
        while (!apb.penable && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reached_access", 32'(apb.penable), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_psel", 32'(apb.psel), 32'd0);
        chk("async_rst_penable", 32'(apb.penable), 32'd0);
        chk("async_rst_rvalid", 32'(rvalid_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv = 0;
        repeat (20) begin
            @(negedge clk);
            if (rvalid_o) rv++;
        end
        chk("no_rvalid_after_reset", 32'(rv), 32'd0);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return LO;
            1:       return HI;
            2:       return LO - 32'd1;
            3:       return HI + 32'd1;
            4:       return $urandom;
            default: return LO + ($urandom % (HI - LO + 32'd1));
        endcase
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return $urandom_range(TMO - 1, TMO + 1);
        return NEVER;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        req_i   = 1'b0;
        addr_i  = '0;
        we_i    = 1'b0;
        be_i    = '0;
        wdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_psel", 32'(apb.psel), 32'd0);
        chk("rst_penable", 32'(apb.penable), 32'd0);
        chk("rst_pwrite", 32'(apb.pwrite), 32'd0);
        chk("rst_paddr", apb.paddr, 32'd0);
        chk("rst_pwdata", apb.pwdata, 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(32'h1A10_1000, 1'b0, 4'hF, 32'h0,        0,     1'b0, 32'hCAFE_0001);
        do_txn(32'h1A10_3004, 1'b1, 4'hF, 32'h0000_00FF, 3,     1'b0, 32'h1234_5678);
        do_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0,        0,     1'b0, 32'h1111_1111);
        do_txn(32'h1A10_2000, 1'b1, 4'h3, 32'hABCD_0000, 0,     1'b0, 32'h0);
        do_txn(32'h1A10_4000, 1'b0, 4'hF, 32'h0,        NEVER, 1'b0, 32'h2222_2222);
        do_txn(32'h1A10_4004, 1'b0, 4'hF, 32'h0,        1,     1'b0, 32'h3333_3333);
        do_txn(32'h1A10_5000, 1'b0, 4'hF, 32'h0,        0,     1'b1, 32'h4444_4444);
        do_txn(32'h1A10_6000, 1'b0, 4'hF, 32'h0,        TMO,   1'b0, 32'h5555_5555);
        do_txn(LO,            1'b0, 4'hF, 32'h0,        2,     1'b0, 32'h6666_6666);
        do_txn(HI,            1'b1, 4'hF, 32'h7777_7777, 1,     1'b0, 32'h0);
        do_txn(LO - 32'd1,    1'b0, 4'hF, 32'h0,        0,     1'b0, 32'h8888_8888);
        do_txn(HI + 32'd1,    1'b1, 4'hF, 32'h0,        0,     1'b0, 32'h0);
        do_txn(32'h1A20_0000, 1'b0, 4'h1, 32'h0,        0,     1'b0, 32'h9999_9999);

        reset_mid();
        do_txn(32'h1A10_0040, 1'b0, 4'hF, 32'h0,        0,     1'b0, 32'hBEEF_0002);

        for (int i = 0; i < 150; i++) begin
            logic        w;
            logic [3:0]  b;
            w = 1'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            do_txn(pick_addr(), w, b, $urandom, pick_wait(),
                   ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
